// File: rtl/axe_clk_monitor.sv
// ---------------------------------------------------------------------------
// axe_clk_monitor
//
// Measures the period and high time of an asynchronous monitored clock using
// the local reference clock as the timebase. Results are counts of reference
// cycles accumulated over 2^LOG2_N monitored periods. Also flags results that
// fall outside a programmable window and detects a stopped monitored clock.
//
// Ports:
//   i_clk         reference clock (timebase)
//   i_rst_n       synchronous, active-low reset
//   i_enable      measurement enable; dropping it discards any partial window
//   i_mon_clk     monitored clock, asynchronous, sampled as data
//   i_min_period  lower bound on the accumulated period count
//   i_max_period  upper bound on the accumulated period count
//   o_valid       one-cycle pulse when o_period/o_high are updated
//   o_period      accumulated period count (reference cycles)
//   o_high        accumulated high-time count (reference cycles)
//   o_stopped     level, monitored clock has had no rising edge for TIMEOUT
//   o_range_err   sticky, some result fell outside [i_min_period, i_max_period]
// ---------------------------------------------------------------------------
module axe_clk_monitor #(
  parameter int CNT_W   = 20,
  parameter int LOG2_N  = 0,
  parameter int TIMEOUT = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_mon_clk,
  input  logic [CNT_W-1:0] i_min_period,
  input  logic [CNT_W-1:0] i_max_period,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_stopped,
  output logic             o_range_err
);

  localparam int               GAP_W    = $clog2(TIMEOUT + 1);
  localparam logic [7:0]       IDX_LAST = 8'((1 << LOG2_N) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    MEASURE,
    STOPPED
  } state_t;

  state_t           state;
  logic             sync_1;
  logic             sync_2;
  logic             mon_prev;
  logic             rise;
  logic             mon_hi;
  logic [CNT_W-1:0] per_acc;
  logic [CNT_W-1:0] high_acc;
  logic [CNT_W-1:0] per_next;
  logic [CNT_W-1:0] high_next;
  logic [CNT_W-1:0] high_start;
  logic [7:0]       idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             timeout_hit;
  logic             out_of_range;

  // The rising edge is detected on the synchronized copy, so the edge and the
  // level seen by the accumulators are always consistent with each other.
  assign rise   = sync_2 & ~mon_prev;
  assign mon_hi = sync_2;

  // Saturating increments; the accumulators stick at all-ones instead of
  // wrapping so an overlong window still reports a recognisable value.
  assign per_next   = (per_acc == CNT_MAX) ? per_acc : per_acc + CNT_ONE;
  assign high_next  = (mon_hi && (high_acc != CNT_MAX)) ? high_acc + CNT_ONE : high_acc;

  // A rising edge cycle belongs to the new period, so a restart counts it as
  // the first cycle of the next window (period 1, high 1 since the clock is high).
  assign high_start = mon_hi ? CNT_ONE : '0;

  // gap_cnt holds the number of consecutive edge-free cycles already seen, so
  // this cycle being edge-free too makes TIMEOUT of them. An edge in the
  // same cycle always wins over the timeout.
  assign timeout_hit  = ~rise && (gap_cnt == GAP_LAST);
  assign out_of_range = (per_acc < i_min_period) || (per_acc > i_max_period);

  // Two-flop synchronizer for the asynchronous monitored clock, followed by a
  // third flop that remembers the previous synchronized level for edge detect.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      mon_prev <= 1'b0;
    end else begin
      sync_1   <= i_mon_clk;
      sync_2   <= sync_1;
      mon_prev <= sync_2;
    end
  end

  // Measurement state machine with registered outputs. Disable has priority
  // over everything else: it drops back to IDLE, throws away the partial
  // window and clears o_stopped, while the last results and the sticky range
  // flag are left untouched. Windows are back to back: the edge that closes
  // one window is also the first cycle of the next one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      per_acc     <= '0;
      high_acc    <= '0;
      idx         <= '0;
      gap_cnt     <= '0;
      o_valid     <= 1'b0;
      o_period    <= '0;
      o_high      <= '0;
      o_stopped   <= 1'b0;
      o_range_err <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_enable) begin
        state     <= IDLE;
        per_acc   <= '0;
        high_acc  <= '0;
        idx       <= '0;
        gap_cnt   <= '0;
        o_stopped <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            gap_cnt <= '0;
            state   <= ACQUIRE;
          end

          ACQUIRE: begin
            if (rise) begin
              per_acc  <= CNT_ONE;
              high_acc <= high_start;
              idx      <= '0;
              gap_cnt  <= '0;
              state    <= MEASURE;
            end else if (timeout_hit) begin
              o_stopped <= 1'b1;
              state     <= STOPPED;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end

          MEASURE: begin
            if (rise) begin
              gap_cnt <= '0;
              if (idx == IDX_LAST) begin
                o_valid  <= 1'b1;
                o_period <= per_acc;
                o_high   <= high_acc;
                if (out_of_range) begin
                  o_range_err <= 1'b1;
                end
                per_acc  <= CNT_ONE;
                high_acc <= high_start;
                idx      <= '0;
              end else begin
                per_acc  <= per_next;
                high_acc <= high_next;
                idx      <= idx + 8'd1;
              end
            end else if (timeout_hit) begin
              per_acc   <= '0;
              high_acc  <= '0;
              idx       <= '0;
              o_stopped <= 1'b1;
              state     <= STOPPED;
            end else begin
              gap_cnt  <= gap_cnt + GAP_W'(1);
              per_acc  <= per_next;
              high_acc <= high_next;
            end
          end

          STOPPED: begin
            if (rise) begin
              o_stopped <= 1'b0;
              per_acc   <= CNT_ONE;
              high_acc  <= high_start;
              idx       <= '0;
              gap_cnt   <= '0;
              state     <= MEASURE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axe_clk_monitor.sv
// ---------------------------------------------------------------------------
// tb_axe_clk_monitor
//
// Three monitor instances share one monitored clock and reset:
//   dut_a  CNT_W=20, LOG2_N=0  single-period results, stop detection
//   dut_b  CNT_W=20, LOG2_N=2  4-period windows, range flag, disable, reset
//   dut_c  CNT_W=8,  LOG2_N=8  stuck-high clock and saturation
// Each scenario enables only the instance it targets. Expected results are
// queued when the stimulus is set up; observed o_valid results are queued as
// they appear and compared against the expectations.
// ---------------------------------------------------------------------------
module tb_axe_clk_monitor;

  typedef struct {
    int per_lo;
    int per_hi;
    int hi_lo;
    int hi_hi;
  } exp_t;

  typedef struct {
    int period;
    int high;
    int cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a;
  logic        en_b;
  logic        en_c;
  logic        mon_clk;
  logic [19:0] min_a = 20'd9;
  logic [19:0] max_a = 20'd11;
  logic [19:0] min_b = 20'd38;
  logic [19:0] max_b = 20'd42;
  logic [7:0]  min_c = 8'd38;
  logic [7:0]  max_c = 8'd42;

  logic        valid_a, stopped_a, rerr_a;
  logic [19:0] period_a, high_a;
  logic        valid_b, stopped_b, rerr_b;
  logic [19:0] period_b, high_b;
  logic        valid_c, stopped_c, rerr_c;
  logic [7:0]  period_c, high_c;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   mon_mode    = 1;
  int   mon_period  = 10;
  int   mon_high    = 4;
  int   mon_phase   = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t exp_c[$];
  obs_t obs_a[$];
  obs_t obs_b[$];
  obs_t obs_c[$];

  axe_clk_monitor #(.CNT_W(20), .LOG2_N(0), .TIMEOUT(1024)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en_a), .i_mon_clk(mon_clk),
    .i_min_period(min_a), .i_max_period(max_a),
    .o_valid(valid_a), .o_period(period_a), .o_high(high_a),
    .o_stopped(stopped_a), .o_range_err(rerr_a)
  );

  axe_clk_monitor #(.CNT_W(20), .LOG2_N(2), .TIMEOUT(1024)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en_b), .i_mon_clk(mon_clk),
    .i_min_period(min_b), .i_max_period(max_b),
    .o_valid(valid_b), .o_period(period_b), .o_high(high_b),
    .o_stopped(stopped_b), .o_range_err(rerr_b)
  );

  axe_clk_monitor #(.CNT_W(8), .LOG2_N(8), .TIMEOUT(1024)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en_c), .i_mon_clk(mon_clk),
    .i_min_period(min_c), .i_max_period(max_c),
    .o_valid(valid_c), .o_period(period_c), .o_high(high_c),
    .o_stopped(stopped_c), .o_range_err(rerr_c)
  );

  always #5 clk = ~clk;

  // Advance n reference cycles. The monitored clock is driven 1 time unit
  // after each rising edge (mode 0 = periodic, 1 = held low, 2 = held high),
  // and every o_valid pulse is captured on the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (mon_mode == 0) begin
        mon_phase = (mon_phase + 1 >= mon_period) ? 0 : mon_phase + 1;
        mon_clk   = (mon_phase < mon_high);
      end else begin
        mon_clk = (mon_mode == 2);
      end
      @(negedge clk);
      if (valid_a === 1'b1) obs_a.push_back(obs_t'{int'(period_a), int'(high_a), cyc});
      if (valid_b === 1'b1) obs_b.push_back(obs_t'{int'(period_b), int'(high_b), cyc});
      if (valid_c === 1'b1) obs_c.push_back(obs_t'{int'(period_c), int'(high_c), cyc});
    end
  endtask

  // Restart the periodic monitored clock so its next step is a rising edge.
  task automatic mon_start(input int period, input int high);
    mon_period = period;
    mon_high   = high;
    mon_phase  = period - 1;
    mon_mode   = 0;
  endtask

  function automatic int obs_size(input int which);
    case (which)
      0:       return obs_a.size();
      1:       return obs_b.size();
      default: return obs_c.size();
    endcase
  endfunction

  // Bounded wait until at least count results are captured for an instance.
  task automatic wait_obs(input int which, input int count, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n <= budget; n++) begin
      if (obs_size(which) >= count) begin
        ok = 1'b1;
        break;
      end
      if (n < budget) step(1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    vectors++;
    if ({period_a, high_a, period_b, high_b, period_c, high_c} !== 96'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got a=%0d/%0d b=%0d/%0d c=%0d/%0d, expected all 0",
               period_a, high_a, period_b, high_b, period_c, high_c);
    end
    vectors++;
    if ({valid_a, stopped_a, rerr_a, valid_b, stopped_b, rerr_b, valid_c, stopped_c, rerr_c} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, expected 000000000",
               {valid_a, stopped_a, rerr_a, valid_b, stopped_b, rerr_b, valid_c, stopped_c, rerr_c});
    end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_basic();
    exp_t e;
    obs_t o;
    bit   ok;
    int   start;
    int   first_lat;
    int   spacing;
    mon_start(10, 4);
    en_a  = 1'b1;
    start = cyc;
    for (int i = 0; i < 4; i++) exp_a.push_back(exp_t'{10, 10, 4, 4});
    wait_obs(0, 4, 120, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL basic_count: got %0d results, expected 4", obs_a.size());
    end
    first_lat = (obs_a.size() > 0) ? obs_a[0].cyc - start : -1;
    spacing   = (obs_a.size() > 3) ? obs_a[3].cyc - obs_a[2].cyc : -1;
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front();
      o = obs_a.pop_front();
      vectors++;
      if (o.period < e.per_lo || o.period > e.per_hi || o.high < e.hi_lo || o.high > e.hi_hi) begin
        miscompares++;
        $display("[TB] FAIL basic_result: got period=%0d high=%0d, expected %0d/%0d", o.period, o.high, e.per_lo, e.hi_lo);
      end
    end
    exp_a.delete();
    vectors++;
    if (first_lat < 12 || first_lat > 24) begin
      miscompares++;
      $display("[TB] FAIL basic_first_latency: got %0d cycles, expected 12..24", first_lat);
    end
    vectors++;
    if (spacing != 10) begin
      miscompares++;
      $display("[TB] FAIL basic_spacing: got %0d cycles, expected 10", spacing);
    end
    vectors++;
    if (rerr_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_range_err: got %b, expected 0", rerr_a);
    end
  endtask

  task automatic test_stopped();
    exp_t e;
    obs_t o;
    bit   ok;
    mon_mode = 1;
    step(1000);
    vectors++;
    if (stopped_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stop_early: got o_stopped=%b at 1000 cycles, expected 0", stopped_a);
    end
    step(100);
    vectors++;
    if (stopped_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stop_assert: got o_stopped=%b at 1100 cycles, expected 1", stopped_a);
    end
    vectors++;
    if (obs_a.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL stop_no_valid: got %0d results while stopped, expected 0", obs_a.size());
    end
    obs_a.delete();
    mon_start(10, 4);
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step(1);
      if (stopped_a === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL stop_clear: got o_stopped=%b 8 cycles after resume, expected 0", stopped_a);
    end
    exp_a.push_back(exp_t'{10, 10, 4, 4});
    wait_obs(0, 1, 20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL stop_recover_count: got %0d results, expected 1", obs_a.size());
    end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front();
      o = obs_a.pop_front();
      vectors++;
      if (o.period != e.per_lo || o.high != e.hi_lo) begin
        miscompares++;
        $display("[TB] FAIL stop_recover_result: got period=%0d high=%0d, expected %0d/%0d", o.period, o.high, e.per_lo, e.hi_lo);
      end
    end
    exp_a.delete();
    en_a = 1'b0;
    step(2);
  endtask

  task automatic test_range();
    exp_t e;
    obs_t o;
    bit   ok;
    en_b = 1'b1;
    for (int phase = 0; phase < 3; phase++) begin
      if (phase == 0) begin
        for (int i = 0; i < 3; i++) exp_b.push_back(exp_t'{40, 40, 16, 16});
      end else if (phase == 1) begin
        mon_period = 12;
        mon_high   = 6;
        exp_b.push_back(exp_t'{40, 48, 16, 24});
        exp_b.push_back(exp_t'{48, 48, 24, 24});
        exp_b.push_back(exp_t'{48, 48, 24, 24});
      end else begin
        mon_period = 10;
        mon_high   = 4;
        exp_b.push_back(exp_t'{40, 48, 16, 24});
        exp_b.push_back(exp_t'{40, 40, 16, 16});
      end
      wait_obs(1, exp_b.size(), 250, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("[TB] FAIL range_count_%0d: got %0d results, expected %0d", phase, obs_b.size(), exp_b.size());
      end
      while (exp_b.size() > 0 && obs_b.size() > 0) begin
        e = exp_b.pop_front();
        o = obs_b.pop_front();
        vectors++;
        if (o.period < e.per_lo || o.period > e.per_hi || o.high < e.hi_lo || o.high > e.hi_hi) begin
          miscompares++;
          $display("[TB] FAIL range_result_%0d: got period=%0d high=%0d, expected period %0d..%0d high %0d..%0d",
                   phase, o.period, o.high, e.per_lo, e.per_hi, e.hi_lo, e.hi_hi);
        end
      end
      exp_b.delete();
      vectors++;
      if (rerr_b !== ((phase == 0) ? 1'b0 : 1'b1)) begin
        miscompares++;
        $display("[TB] FAIL range_err_%0d: got %b, expected %b", phase, rerr_b, (phase == 0) ? 1'b0 : 1'b1);
      end
    end
  endtask

  task automatic test_disable();
    step(15);
    en_b = 1'b0;
    step(60);
    vectors++;
    if (obs_b.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL disable_no_valid: got %0d results after disable, expected 0", obs_b.size());
    end
    obs_b.delete();
    vectors++;
    if (period_b !== 20'd40 || high_b !== 20'd16) begin
      miscompares++;
      $display("[TB] FAIL disable_hold: got period=%0d high=%0d, expected 40/16", period_b, high_b);
    end
    vectors++;
    if (rerr_b !== 1'b1 || stopped_b !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL disable_flags: got range_err=%b stopped=%b, expected 1/0", rerr_b, stopped_b);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    obs_t o;
    bit   ok;
    en_b = 1'b1;
    step(25);
    rst_n = 1'b0;
    step(1);
    vectors++;
    if (period_b !== 20'd0 || high_b !== 20'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_values: got period=%0d high=%0d, expected 0/0", period_b, high_b);
    end
    vectors++;
    if ({valid_b, stopped_b, rerr_b} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_flags: got %b, expected 000", {valid_b, stopped_b, rerr_b});
    end
    rst_n = 1'b1;
    exp_b.push_back(exp_t'{40, 40, 16, 16});
    wait_obs(1, 1, 80, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_restart: got %0d results, expected 1", obs_b.size());
    end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front();
      o = obs_b.pop_front();
      vectors++;
      if (o.period != e.per_lo || o.high != e.hi_lo) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_result: got period=%0d high=%0d, expected %0d/%0d", o.period, o.high, e.per_lo, e.hi_lo);
      end
    end
    exp_b.delete();
    en_b = 1'b0;
    step(2);
  endtask

  task automatic test_stuck_high();
    mon_mode = 2;
    step(5);
    en_c = 1'b1;
    step(1000);
    vectors++;
    if (stopped_c !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stuck_early: got o_stopped=%b at 1000 cycles, expected 0", stopped_c);
    end
    step(40);
    vectors++;
    if (stopped_c !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stuck_stop: got o_stopped=%b at 1040 cycles, expected 1", stopped_c);
    end
    vectors++;
    if (obs_c.size() != 0 || period_c !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL stuck_no_valid: got %0d results period=%0d, expected 0/0", obs_c.size(), period_c);
    end
    obs_c.delete();
    en_c = 1'b0;
    step(1);
    vectors++;
    if (stopped_c !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stuck_disable_clear: got o_stopped=%b, expected 0", stopped_c);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    obs_t o;
    bit   ok;
    mon_start(2, 1);
    en_c = 1'b1;
    exp_c.push_back(exp_t'{255, 255, 255, 255});
    wait_obs(2, 1, 700, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL sat_count: got %0d results, expected 1", obs_c.size());
    end
    while (exp_c.size() > 0 && obs_c.size() > 0) begin
      e = exp_c.pop_front();
      o = obs_c.pop_front();
      vectors++;
      if (o.period != e.per_lo || o.high != e.hi_lo) begin
        miscompares++;
        $display("[TB] FAIL sat_result: got period=%0d high=%0d, expected %0d/%0d", o.period, o.high, e.per_lo, e.hi_lo);
      end
    end
    exp_c.delete();
    vectors++;
    if (rerr_c !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sat_range_err: got %b, expected 1", rerr_c);
    end
    en_c = 1'b0;
    step(2);
  endtask

  initial begin
    rst_n   = 1'b0;
    en_a    = 1'b0;
    en_b    = 1'b0;
    en_c    = 1'b0;
    mon_clk = 1'b0;
    $display("[TB] axe_clk_monitor bench start");
    test_reset();
    test_basic();
    test_stopped();
    test_range();
    test_disable();
    test_reset_mid();
    test_stuck_high();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
